// File: rtl/bfp16_pkg.sv
// BFP16 field layout and helpers shared by the compare-exchange datapath.
// Keys map the sign-magnitude encoding onto an unsigned total order.
package bfp16_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 7;
    localparam int BFP_W  = SIGN_W + EXP_W + MAN_W;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } bfp16_t;

    // Positive values move above all negatives; negatives invert so larger magnitude sorts lower.
    function automatic logic [BFP_W-1:0] bfp16_key(input bfp16_t x);
        logic [BFP_W-1:0] raw;
        raw = x;
        return x.sign ? ~raw : (raw ^ 16'h8000);
    endfunction

    function automatic logic is_nan(input bfp16_t x);
        return (x.exp == EXP_MAX) && (x.man != '0);
    endfunction

    function automatic logic is_zero(input bfp16_t x);
        return {x.exp, x.man} == '0;
    endfunction

endpackage

// File: rtl/bfp16_cmp_swap_if.sv
// Input-pair and output-pair handshake bundle of the compare-exchange cell.
interface bfp16_cmp_swap_if #(
    parameter int TAG_W = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [15:0]      i_data_a;
    logic [15:0]      i_data_b;
    logic [TAG_W-1:0] i_tag_a;
    logic [TAG_W-1:0] i_tag_b;
    logic             o_valid;
    logic             i_ready;
    logic [15:0]      o_lo;
    logic [15:0]      o_hi;
    logic [TAG_W-1:0] o_tag_lo;
    logic [TAG_W-1:0] o_tag_hi;
    logic             o_swapped;
    logic             o_equal;

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_tag_a, i_tag_b, i_ready,
        output o_ready, o_valid, o_lo, o_hi, o_tag_lo, o_tag_hi, o_swapped, o_equal
    );

    modport master (
        output i_valid, i_data_a, i_data_b, i_tag_a, i_tag_b, i_ready,
        input  o_ready, o_valid, o_lo, o_hi, o_tag_lo, o_tag_hi, o_swapped, o_equal
    );
endinterface

// File: rtl/bfp16_key_cmp.sv
// 16-bit key magnitude compare split into four nibble less/equal pairs.
// Index 3 is the most significant nibble.
module bfp16_key_cmp (
    input  logic [15:0] i_key_x,
    input  logic [15:0] i_key_y,
    output logic [3:0]  o_lt,
    output logic [3:0]  o_eq
);

    always_comb begin
        o_lt = '0;
        o_eq = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            o_lt[i] = i_key_x[i*4 +: 4] <  i_key_y[i*4 +: 4];
            o_eq[i] = i_key_x[i*4 +: 4] == i_key_y[i*4 +: 4];
        end
    end

endmodule

// File: rtl/bfp16_cmp_swap.sv
// Two-stage compare-exchange cell: S1 registers operands and nibble compares,
// S2 resolves ordering with NaN/zero rules and registers the routed pair.
module bfp16_cmp_swap
    import bfp16_pkg::*;
#(
    parameter int TAG_W   = 8,
    parameter bit DESCEND = 1'b0
) (
    input logic             i_clk,
    input logic             i_rst,
    bfp16_cmp_swap_if.slave bus
);

    logic             s1_valid_q, s1_valid_d;
    bfp16_t           s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_ta_q, s1_ta_d, s1_tb_q, s1_tb_d;
    logic [3:0]       s1_lt_q, s1_lt_d, s1_eq_q, s1_eq_d;

    logic             s2_valid_q, s2_valid_d;
    logic [15:0]      lo_q, lo_d, hi_q, hi_d;
    logic [TAG_W-1:0] tlo_q, tlo_d, thi_q, thi_d;
    logic             swapped_q, swapped_d, equal_q, equal_d;

    logic             in_ready, s1_load, s2_load;
    logic [15:0]      key_a, key_b;
    logic [3:0]       nib_lt, nib_eq;
    logic             b_less_a, pair_equal;
    logic             a_nan, b_nan;

    assign key_a = bfp16_key(bus.i_data_a);
    assign key_b = bfp16_key(bus.i_data_b);

    // Compare B against A so that the nibble "less" flags directly mean b < a.
    bfp16_key_cmp u_key_cmp (
        .i_key_x (key_b),
        .i_key_y (key_a),
        .o_lt    (nib_lt),
        .o_eq    (nib_eq)
    );

    always_comb begin
        s2_load  = s1_valid_q & (~s2_valid_q | bus.i_ready);
        in_ready = ~s1_valid_q | s2_load;
        s1_load  = bus.i_valid & in_ready;
    end

    always_comb begin
        a_nan      = is_nan(s1_a_q);
        b_nan      = is_nan(s1_b_q);
        b_less_a   = s1_lt_q[3]
                   | (s1_eq_q[3] & s1_lt_q[2])
                   | (s1_eq_q[3] & s1_eq_q[2] & s1_lt_q[1])
                   | (s1_eq_q[3] & s1_eq_q[2] & s1_eq_q[1] & s1_lt_q[0]);
        pair_equal = &s1_eq_q;
        if (a_nan && b_nan) begin
            b_less_a   = 1'b0;
            pair_equal = 1'b1;
        end else if (a_nan) begin
            b_less_a   = 1'b1;
            pair_equal = 1'b0;
        end else if (b_nan) begin
            b_less_a   = 1'b0;
            pair_equal = 1'b0;
        end else if (is_zero(s1_a_q) && is_zero(s1_b_q)) begin
            b_less_a   = 1'b0;
            pair_equal = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_ta_d    = s1_ta_q;
        s1_tb_d    = s1_tb_q;
        s1_lt_d    = s1_lt_q;
        s1_eq_d    = s1_eq_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_a_d     = bus.i_data_a;
            s1_b_d     = bus.i_data_b;
            s1_ta_d    = bus.i_tag_a;
            s1_tb_d    = bus.i_tag_b;
            s1_lt_d    = nib_lt;
            s1_eq_d    = nib_eq;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        tlo_d      = tlo_q;
        thi_d      = thi_q;
        swapped_d  = swapped_q;
        equal_d    = equal_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            swapped_d  = b_less_a;
            equal_d    = pair_equal;
            // Descending order is the ascending routing with the two lanes exchanged.
            if (b_less_a ^ DESCEND) begin
                lo_d  = s1_b_q;
                hi_d  = s1_a_q;
                tlo_d = s1_tb_q;
                thi_d = s1_ta_q;
            end else begin
                lo_d  = s1_a_q;
                hi_d  = s1_b_q;
                tlo_d = s1_ta_q;
                thi_d = s1_tb_q;
            end
        end else if (bus.i_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_ta_q    <= '0;
            s1_tb_q    <= '0;
            s1_lt_q    <= '0;
            s1_eq_q    <= '0;
            s2_valid_q <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
            tlo_q      <= '0;
            thi_q      <= '0;
            swapped_q  <= 1'b0;
            equal_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_ta_q    <= s1_ta_d;
            s1_tb_q    <= s1_tb_d;
            s1_lt_q    <= s1_lt_d;
            s1_eq_q    <= s1_eq_d;
            s2_valid_q <= s2_valid_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            tlo_q      <= tlo_d;
            thi_q      <= thi_d;
            swapped_q  <= swapped_d;
            equal_q    <= equal_d;
        end
    end

    assign bus.o_ready   = in_ready;
    assign bus.o_valid   = s2_valid_q;
    assign bus.o_lo      = lo_q;
    assign bus.o_hi      = hi_q;
    assign bus.o_tag_lo  = tlo_q;
    assign bus.o_tag_hi  = thi_q;
    assign bus.o_swapped = swapped_q;
    assign bus.o_equal   = equal_q;

endmodule

// File: tb/tb_bfp16_cmp_swap.sv
// Directed-vector and handshake-sequence bench for bfp16_cmp_swap,
// run on an ascending and a descending instance sharing one stimulus stream.
module tb_bfp16_cmp_swap;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  ta;
        logic [7:0]  tb;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [7:0]  tlo;
        logic [7:0]  thi;
        logic        sw;
        logic        eq;
    } vec_t;

    logic clk;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    bfp16_cmp_swap_if #(.TAG_W(8)) bus_a ();
    bfp16_cmp_swap_if #(.TAG_W(8)) bus_d ();

    assign bus_d.i_valid  = bus_a.i_valid;
    assign bus_d.i_data_a = bus_a.i_data_a;
    assign bus_d.i_data_b = bus_a.i_data_b;
    assign bus_d.i_tag_a  = bus_a.i_tag_a;
    assign bus_d.i_tag_b  = bus_a.i_tag_b;
    assign bus_d.i_ready  = bus_a.i_ready;

    bfp16_cmp_swap #(.TAG_W(8), .DESCEND(1'b0)) u_asc (.i_clk(clk), .i_rst(rst), .bus(bus_a));
    bfp16_cmp_swap #(.TAG_W(8), .DESCEND(1'b1)) u_dsc (.i_clk(clk), .i_rst(rst), .bus(bus_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Independent sign-magnitude reference ordering.
    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic bla, output logic eq);
        logic an, bn;
        an = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
        bn = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
        eq = 1'b0;
        if (an && bn)                          begin bla = 1'b0; eq = 1'b1; end
        else if (an)                           bla = 1'b1;
        else if (bn)                           bla = 1'b0;
        else if (a[14:0] == 0 && b[14:0] == 0) begin bla = 1'b0; eq = 1'b1; end
        else if (a == b)                       begin bla = 1'b0; eq = 1'b1; end
        else if (a[15] != b[15])               bla = ~b[15] ? 1'b0 : 1'b1;
        else if (!a[15])                       bla = b[14:0] < a[14:0];
        else                                   bla = b[14:0] > a[14:0];
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        @(posedge clk); #1;
        bus_a.i_valid  = 1'b1;
        bus_a.i_data_a = v.a;
        bus_a.i_data_b = v.b;
        bus_a.i_tag_a  = v.ta;
        bus_a.i_tag_b  = v.tb;
        bus_a.i_ready  = 1'b1;
        chk($sformatf("v%0d_ready", idx), 64'(bus_a.o_ready), 64'd1);
        @(posedge clk); #1;
        bus_a.i_valid = 1'b0;
        chk($sformatf("v%0d_lat1", idx), 64'(bus_a.o_valid), 64'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_lat2", idx), 64'(bus_a.o_valid), 64'd1);
        chk($sformatf("v%0d_lo", idx),  64'(bus_a.o_lo), 64'(v.lo));
        chk($sformatf("v%0d_hi", idx),  64'(bus_a.o_hi), 64'(v.hi));
        chk($sformatf("v%0d_tags", idx), 64'({bus_a.o_tag_lo, bus_a.o_tag_hi}), 64'({v.tlo, v.thi}));
        chk($sformatf("v%0d_sw", idx),  64'(bus_a.o_swapped), 64'(v.sw));
        chk($sformatf("v%0d_eq", idx),  64'(bus_a.o_equal), 64'(v.eq));
        chk($sformatf("v%0d_dsc", idx),
            64'({bus_d.o_lo, bus_d.o_hi, bus_d.o_tag_lo, bus_d.o_tag_hi, bus_d.o_swapped, bus_d.o_equal}),
            64'({v.hi, v.lo, v.thi, v.tlo, v.sw, v.eq}));
    endtask

    function automatic logic [15:0] pick_val();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7F80;
            3: return 16'hFF80;
            4: return {r[15], 8'hFF, (r[6:0] == 7'd0) ? 7'd1 : r[6:0]};
            5: return {r[15], 8'h00, r[6:0]};
            default: return r;
        endcase
    endfunction

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{16'h3F80, 16'h4000, 8'd1,  8'd2,  16'h3F80, 16'h4000, 8'd1,  8'd2,  1'b0, 1'b0};
        vecs[1]  = '{16'h3F80, 16'hC000, 8'd3,  8'd4,  16'hC000, 16'h3F80, 8'd4,  8'd3,  1'b1, 1'b0};
        vecs[2]  = '{16'h8000, 16'h0000, 8'd5,  8'd6,  16'h8000, 16'h0000, 8'd5,  8'd6,  1'b0, 1'b1};
        vecs[3]  = '{16'h7FC1, 16'h7F80, 8'd7,  8'd8,  16'h7F80, 16'h7FC1, 8'd8,  8'd7,  1'b1, 1'b0};
        vecs[4]  = '{16'hFFC0, 16'h7F81, 8'd9,  8'd10, 16'hFFC0, 16'h7F81, 8'd9,  8'd10, 1'b0, 1'b1};
        vecs[5]  = '{16'h7F80, 16'hFFC0, 8'd11, 8'd12, 16'h7F80, 16'hFFC0, 8'd11, 8'd12, 1'b0, 1'b0};
        vecs[6]  = '{16'hBF80, 16'hFF80, 8'd13, 8'd14, 16'hFF80, 16'hBF80, 8'd14, 8'd13, 1'b1, 1'b0};
        vecs[7]  = '{16'h4040, 16'h4040, 8'd15, 8'd16, 16'h4040, 16'h4040, 8'd15, 8'd16, 1'b0, 1'b1};
        vecs[8]  = '{16'h0001, 16'h0000, 8'd17, 8'd18, 16'h0000, 16'h0001, 8'd18, 8'd17, 1'b1, 1'b0};
        vecs[9]  = '{16'hC000, 16'hBF80, 8'd19, 8'd20, 16'hC000, 16'hBF80, 8'd19, 8'd20, 1'b0, 1'b0};
        vecs[10] = '{16'h8001, 16'h8000, 8'd21, 8'd22, 16'h8001, 16'h8000, 8'd21, 8'd22, 1'b0, 1'b0};
        vecs[11] = '{16'h4012, 16'h4011, 8'd23, 8'd24, 16'h4011, 16'h4012, 8'd24, 8'd23, 1'b1, 1'b0};

        rst = 1'b1;
        bus_a.i_valid  = 1'b0;
        bus_a.i_data_a = '0;
        bus_a.i_data_b = '0;
        bus_a.i_tag_a  = '0;
        bus_a.i_tag_b  = '0;
        bus_a.i_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus_a.o_valid), 64'd0);
        chk("rst_outs", 64'({bus_a.o_lo, bus_a.o_hi, bus_a.o_tag_lo, bus_a.o_tag_hi,
                             bus_a.o_swapped, bus_a.o_equal}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 64'(bus_a.o_ready), 64'd1);

        for (int i = 0; i < 12; i++) apply_vec(i, vecs[i]);

        // Backpressure: six back-to-back pairs, downstream stalled for cycles 3..6.
        begin
            int          sent = 0, got = 0;
            logic        saw_low = 1'b0, stable_ok = 1'b1, have_ref = 1'b0;
            logic [31:0] ref_out = '0;
            logic [47:0] outs[6];
            for (int c = 0; c < 60 && got < 6; c++) begin
                @(posedge clk); #1;
                bus_a.i_ready = !(c >= 3 && c <= 6);
                bus_a.i_valid = (sent < 6);
                bus_a.i_data_a = sent[0] ? 16'h4100 + 16'(sent) : 16'h3F00 + 16'(sent);
                bus_a.i_data_b = sent[0] ? 16'h3F00 + 16'(sent) : 16'h4100 + 16'(sent);
                bus_a.i_tag_a  = 8'(sent * 2);
                bus_a.i_tag_b  = 8'(sent * 2 + 1);
                @(negedge clk);
                if (!bus_a.o_ready) saw_low = 1'b1;
                if (bus_a.o_valid && !bus_a.i_ready) begin
                    if (!have_ref) begin
                        ref_out  = {bus_a.o_lo, bus_a.o_hi};
                        have_ref = 1'b1;
                    end else if ({bus_a.o_lo, bus_a.o_hi} != ref_out) stable_ok = 1'b0;
                end
                if (bus_a.o_valid && bus_a.i_ready) begin
                    outs[got] = {bus_a.o_lo, bus_a.o_hi, bus_a.o_tag_lo, bus_a.o_tag_hi};
                    got++;
                end
                if (bus_a.i_valid && bus_a.o_ready) sent++;
            end
            bus_a.i_valid = 1'b0;
            bus_a.i_ready = 1'b1;
            chk("bp_count", 64'(got), 64'd6);
            chk("bp_ready_drop", 64'(saw_low), 64'd1);
            chk("bp_stable", 64'(stable_ok & have_ref), 64'd1);
            for (int k = 0; k < 6; k++) begin
                logic [7:0] tl, th;
                tl = k[0] ? 8'(k * 2 + 1) : 8'(k * 2);
                th = k[0] ? 8'(k * 2)     : 8'(k * 2 + 1);
                chk($sformatf("bp_pair%0d", k), 64'(outs[k]),
                    64'({16'h3F00 + 16'(k), 16'h4100 + 16'(k), tl, th}));
            end
        end

        // Reset with both stages holding pairs.
        begin
            logic full = 1'b0;
            bus_a.i_ready = 1'b0;
            for (int c = 0; c < 20 && !full; c++) begin
                @(posedge clk); #1;
                bus_a.i_valid  = 1'b1;
                bus_a.i_data_a = 16'h4000 + 16'(c);
                bus_a.i_data_b = 16'h3F80;
                @(negedge clk);
                if (bus_a.o_valid && !bus_a.o_ready) full = 1'b1;
            end
            chk("mrst_full", 64'(full), 64'd1);
            rst = 1'b1;
            bus_a.i_valid = 1'b0;
            #1;
            chk("mrst_valid", 64'({bus_a.o_valid, bus_d.o_valid}), 64'd0);
            chk("mrst_outs", 64'({bus_a.o_lo, bus_a.o_hi, bus_a.o_tag_lo, bus_a.o_tag_hi,
                                  bus_a.o_swapped, bus_a.o_equal}), 64'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            bus_a.i_ready = 1'b1;
            chk("mrst_ready", 64'(bus_a.o_ready), 64'd1);
            apply_vec(100, vecs[1]);
        end

        // Random traffic with random downstream stalls against the reference ordering.
        begin
            localparam int N = 3000;
            logic [63:0] expq[$];
            logic [63:0] e;
            int          n_gen = 0, n_acc = 0, n_out = 0;
            logic        have = 1'b0, bla, eq;
            logic [15:0] ra, rb;
            logic [7:0]  rta, rtb;
            for (int c = 0; c < 40000 && (n_acc < N || expq.size() > 0); c++) begin
                @(posedge clk); #1;
                if (!have && n_gen < N && $urandom_range(0, 3) != 0) begin
                    ra  = pick_val();
                    rb  = ($urandom_range(0, 7) == 0) ? ra : pick_val();
                    rta = 8'($urandom);
                    rtb = 8'($urandom);
                    have = 1'b1;
                    n_gen++;
                end
                bus_a.i_valid  = have;
                bus_a.i_data_a = ra;
                bus_a.i_data_b = rb;
                bus_a.i_tag_a  = rta;
                bus_a.i_tag_b  = rtb;
                bus_a.i_ready  = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (bus_a.i_valid && bus_a.o_ready) begin
                    model(ra, rb, bla, eq);
                    expq.push_back(bla ? 64'({rb, ra, rtb, rta, bla, eq})
                                       : 64'({ra, rb, rta, rtb, bla, eq}));
                    have = 1'b0;
                    n_acc++;
                end
                if (bus_a.o_valid && bus_a.i_ready) begin
                    if (expq.size() == 0) begin
                        chk("rand_spurious", 64'd1, 64'd0);
                    end else begin
                        e = expq.pop_front();
                        chk("rand_asc", 64'({bus_a.o_lo, bus_a.o_hi, bus_a.o_tag_lo, bus_a.o_tag_hi,
                                             bus_a.o_swapped, bus_a.o_equal}), e);
                        chk("rand_dsc", 64'({bus_d.o_lo, bus_d.o_hi, bus_d.o_tag_lo, bus_d.o_tag_hi,
                                             bus_d.o_swapped, bus_d.o_equal}),
                            64'({e[33:18], e[49:34], e[9:2], e[17:10], e[1:0]}));
                        n_out++;
                    end
                end
            end
            bus_a.i_valid = 1'b0;
            chk("rand_drained", 64'(n_out), 64'(N));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
